// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch program counter slice.
//   - Next-PC source encodings, listed from highest to lowest priority.
//   - ras_ptr_width(): pointer width for a RAS of a given depth.
package pc_pkg;

  localparam logic [2:0] SRC_TRAP = 3'd0;
  localparam logic [2:0] SRC_TRET = 3'd1;
  localparam logic [2:0] SRC_RET  = 3'd2;
  localparam logic [2:0] SRC_JB   = 3'd3;
  localparam logic [2:0] SRC_HOLD = 3'd4;
  localparam logic [2:0] SRC_SEQ  = 3'd5;

  function automatic int ras_ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control and status bundle between the fetch controller and
// the program counter.
//   Controller -> PC : stall, jb_enable, jb_value, call, ret,
//                      trap_enable, trap_vector, trap_return
//   PC -> controller : pc, pc_next, epc, ras_top, ras_empty, ras_full,
//                      misaligned
// master = fetch controller side, slave = pc_unit side.
interface pc_unit_if #(
  parameter int XLEN = 32
);

  logic            stall;
  logic            jb_enable;
  logic [XLEN-1:0] jb_value;
  logic            call;
  logic            ret;
  logic            trap_enable;
  logic [XLEN-1:0] trap_vector;
  logic            trap_return;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            misaligned;

  modport master (
    output stall, jb_enable, jb_value, call, ret,
           trap_enable, trap_vector, trap_return,
    input  pc, pc_next, epc, ras_top, ras_empty, ras_full, misaligned
  );

  modport slave (
    input  stall, jb_enable, jb_value, call, ret,
           trap_enable, trap_vector, trap_return,
    output pc, pc_next, epc, ras_top, ras_empty, ras_full, misaligned
  );

endinterface

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset : clock and asynchronous active-high reset (clears count)
//   push, pop  : push wdata / drop top; both together replace the top
//   wdata      : return address to store
//   top        : current top entry, 0 when empty
//   empty/full : count is 0 / RAS_DEPTH
// A push while full advances the pointer onto the oldest slot, so the
// oldest return address is silently overwritten and the count saturates.
module ras_stack
  import pc_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = ras_ptr_width(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr_q, top_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_ptr;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_MAX);
  assign top   = empty ? '0 : mem_q[top_ptr_q];

  // Replace-top only makes sense with something on the stack; on an empty
  // stack push+pop falls through to an ordinary push.
  always_comb begin
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    wr_en     = 1'b0;
    wr_ptr    = top_ptr_q;
    if (push && pop && !empty) begin
      wr_en  = 1'b1;
      wr_ptr = top_ptr_q;
    end else if (push) begin
      top_ptr_d = top_ptr_q + PTR_W'(1);
      wr_en     = 1'b1;
      wr_ptr    = top_ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      top_ptr_d = top_ptr_q - PTR_W'(1);
      count_d   = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  // Entry storage needs no reset: nothing is visible until count > 0.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter.
//   clk, reset : clock and asynchronous active-high reset
//   pc_bus     : pc_unit_if slave port carrying stall, jump/branch redirect
//                (with call/ret qualifiers), trap entry/return and the
//                pc, pc_next, epc, RAS status and misaligned outputs.
// Next-PC priority: trap > trap return > RAS return > jump/branch > stall
// > sequential. Redirects always override stall.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic    clk,
  input logic    reset,
  pc_unit_if.slave pc_bus
);

  localparam logic [XLEN-1:0] STEP_X = XLEN'(STEP);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] seq_pc;
  logic [2:0]      src;
  logic            redirect;
  logic            ras_push, ras_pop;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty, ras_full;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .wdata (seq_pc),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_comb begin
    seq_pc = pc_q + STEP_X;
    src    = SRC_SEQ;
    pc_d   = seq_pc;
    if (pc_bus.trap_enable) begin
      src  = SRC_TRAP;
      pc_d = pc_bus.trap_vector;
    end else if (pc_bus.trap_return) begin
      src  = SRC_TRET;
      pc_d = epc_q;
    end else if (pc_bus.jb_enable && pc_bus.ret) begin
      src  = SRC_RET;
      pc_d = ras_empty ? pc_bus.jb_value : ras_top;
    end else if (pc_bus.jb_enable) begin
      src  = SRC_JB;
      pc_d = pc_bus.jb_value;
    end else if (pc_bus.stall) begin
      src  = SRC_HOLD;
      pc_d = pc_q;
    end
    epc_d = pc_bus.trap_enable ? pc_q : epc_q;
  end

  // The RAS only moves when a plain jump/branch wins arbitration, so a
  // simultaneous trap or trap return leaves it untouched.
  assign ras_push = ((src == SRC_RET) || (src == SRC_JB)) && pc_bus.call;
  assign ras_pop  = (src == SRC_RET);

  assign redirect = (src == SRC_TRAP) || (src == SRC_TRET) ||
                    (src == SRC_RET)  || (src == SRC_JB);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= RESET_VECTOR;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign pc_bus.pc         = pc_q;
  assign pc_bus.pc_next    = pc_d;
  assign pc_bus.epc        = epc_q;
  assign pc_bus.ras_top    = ras_top;
  assign pc_bus.ras_empty  = ras_empty;
  assign pc_bus.ras_full   = ras_full;
  // Remainder by a constant STEP; for STEP=1 this is identically zero.
  assign pc_bus.misaligned = redirect && ((pc_d % STEP_X) != '0);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit (RESET_VECTOR=0x100, STEP=4,
// RAS_DEPTH=4). The driver applies one cycle of stimulus, asks the
// reference model for what the DUT must show that cycle, and queues it;
// the monitor pops and compares on the falling edge.
module tb_pc_unit;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          STEP  = 4;
  localparam int          DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        empty;
    logic        full;
    logic        mis;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  pc_unit_if #(.XLEN(XLEN)) pc_bus ();

  pc_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .STEP         (STEP),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (pc_bus.slave)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;

  // Reference model: PC/EPC as plain values, RAS as a queue with the
  // oldest entry at the front and the top at the back.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h at %0t",
               name, act, expv, $time);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic st,
                               input logic jb, input logic [31:0] jbv,
                               input logic cl, input logic rt,
                               input logic tr, input logic [31:0] tv,
                               input logic trr);
    exp_t        e;
    logic [31:0] tgt, top, ret_addr;
    logic        redir;
    @(posedge clk);
    #1;
    reset              = rst;
    pc_bus.stall       = st;
    pc_bus.jb_enable   = jb;
    pc_bus.jb_value    = jbv;
    pc_bus.call        = cl;
    pc_bus.ret         = rt;
    pc_bus.trap_enable = tr;
    pc_bus.trap_vector = tv;
    pc_bus.trap_return = trr;

    if (rst) begin
      m_pc  = RV;
      m_epc = RV;
      m_ras.delete();
    end

    top   = (m_ras.size() > 0) ? m_ras[$] : 32'h0;
    redir = 1'b1;
    if (tr)            tgt = tv;
    else if (trr)      tgt = m_epc;
    else if (jb && rt) tgt = (m_ras.size() == 0) ? jbv : top;
    else if (jb)       tgt = jbv;
    else begin
      redir = 1'b0;
      tgt   = st ? m_pc : m_pc + STEP;
    end

    e.pc      = m_pc;
    e.pc_next = tgt;
    e.epc     = m_epc;
    e.ras_top = top;
    e.empty   = (m_ras.size() == 0);
    e.full    = (m_ras.size() == DEPTH);
    e.mis     = redir && ((tgt % STEP) != 0);
    exp_q.push_back(e);

    if (!rst) begin
      ret_addr = m_pc + STEP;
      if (!tr && !trr && jb) begin
        if (cl && rt) begin
          if (m_ras.size() == 0) m_ras.push_back(ret_addr);
          else m_ras[m_ras.size()-1] = ret_addr;
        end else if (cl) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(ret_addr);
        end else if (rt) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
      end
      if (tr) m_epc = m_pc;
      m_pc = tgt;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0);
  endtask

  task automatic jump(input logic [31:0] t, input logic cl, input logic rt);
    applyStimulus(0, 0, 1, t, cl, rt, 0, 32'h0, 0);
  endtask

  // Monitor: every queued expectation is compared against the live DUT
  // outputs mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("pc",         pc_bus.pc,                e.pc);
      checkOutput("pc_next",    pc_bus.pc_next,           e.pc_next);
      checkOutput("epc",        pc_bus.epc,               e.epc);
      checkOutput("ras_top",    pc_bus.ras_top,           e.ras_top);
      checkOutput("ras_empty",  {31'h0, pc_bus.ras_empty}, {31'h0, e.empty});
      checkOutput("ras_full",   {31'h0, pc_bus.ras_full},  {31'h0, e.full});
      checkOutput("misaligned", {31'h0, pc_bus.misaligned}, {31'h0, e.mis});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r, t;
    reset              = 1'b1;
    pc_bus.stall       = 1'b0;
    pc_bus.jb_enable   = 1'b0;
    pc_bus.jb_value    = '0;
    pc_bus.call        = 1'b0;
    pc_bus.ret         = 1'b0;
    pc_bus.trap_enable = 1'b0;
    pc_bus.trap_vector = '0;
    pc_bus.trap_return = 1'b0;
    m_pc  = RV;
    m_epc = RV;

    // Reset, release, sequential advance.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Stall hold, then redirect overriding stall.
    jump(32'h108, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h200, 0, 0, 0, 0, 0);
    idle(1);

    // Call then return; call/ret without jb_enable are ignored.
    jump(32'h10, 0, 0);
    jump(32'h80, 1, 0);
    applyStimulus(0, 0, 0, 32'h500, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 32'h500, 0, 1, 0, 0, 0);
    jump(32'hDEAD, 0, 1);
    idle(1);

    // Overfill the RAS, drain it, then return from an empty RAS.
    jump(32'h0, 0, 0);
    jump(32'h100, 1, 0);
    jump(32'h200, 1, 0);
    jump(32'h300, 1, 0);
    jump(32'h400, 1, 0);
    jump(32'h500, 1, 0);
    for (int i = 0; i < 5; i++) jump(32'h600, 0, 1);
    idle(1);

    // call+ret on empty and non-empty RAS.
    jump(32'h700, 1, 1);
    jump(32'h740, 1, 1);
    jump(32'h0, 0, 1);
    idle(1);

    // Trap with simultaneous call, then trap return.
    jump(32'h40, 0, 0);
    jump(32'h80, 1, 0);
    jump(32'h40, 0, 0);
    applyStimulus(0, 0, 1, 32'h2000, 1, 0, 1, 32'h1000, 0);
    idle(2);
    applyStimulus(0, 1, 1, 32'h3000, 0, 1, 0, 0, 1);
    idle(1);

    // Wrap, misaligned target, reset mid-stream.
    jump(32'hFFFF_FFF8, 0, 0);
    idle(2);
    jump(32'h102, 0, 0);
    idle(1);
    jump(32'h300, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      t = $urandom;
      if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
      applyStimulus(r < 2,
                    $urandom_range(0, 4) == 0,
                    (r >= 12) && (r < 45),
                    t,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) == 0,
                    (r >= 2) && (r < 7),
                    {$urandom_range(0, 65535), 16'h0} | 32'(($urandom_range(0, 7) == 0) ? 2 : 0),
                    (r >= 7) && (r < 12));
    end
    idle(1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
Parametrised successor to the basic fetch program counter. Holds the PC and advances it by a configurable step. Supports stall, jump/branch redirect, trap entry/return with an EPC register, and a small circular return-address stack (RAS) for call/return targets. Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
XLEN, 32, width of PC, EPC, targets and RAS entries
RESET_VECTOR, 32'h0, PC and EPC value after reset
STEP, 4, sequential increment (1 = word-addressed memory, 4 = byte-addressed)
RAS_DEPTH, 4, number of return-address stack entries (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
stall  input  1  hold PC; blocks sequential advance only
jb_enable  input  1  jump/branch redirect this cycle
jb_value  input  XLEN  jump/branch target
call  input  1  qualifier on jb_enable: push return address
ret  input  1  qualifier on jb_enable: take target from RAS
trap_enable  input  1  trap entry
trap_vector  input  XLEN  trap handler address
trap_return  input  1  return from trap to EPC
pc  output  XLEN  current PC (registered)
pc_next  output  XLEN  combinational next-PC
epc  output  XLEN  saved exception PC (registered)
ras_top  output  XLEN  top RAS entry (0 when empty)
ras_empty  output  1  RAS holds no entries
ras_full  output  1  RAS holds RAS_DEPTH entries
misaligned  output  1  combinational: selected redirect target not a multiple of STEP (always 0 when STEP=1)

Behaviour:
- Reset (asynchronous, active-high): pc=RESET_VECTOR, epc=RESET_VECTOR, RAS count=0, ras_empty=1, ras_full=0, ras_top=0.
- One-cycle latency: pc <= pc_next on every rising edge out of reset.
- pc_next priority, highest first:
  1. trap_enable: trap_vector; epc <= pc.
  2. trap_return: epc.
  3. jb_enable && ret: ras_empty ? jb_value : ras_top.
  4. jb_enable: jb_value.
  5. stall: pc.
  6. Otherwise: pc + STEP, truncated to XLEN (wraps 2^XLEN-STEP -> 0).
- Redirects (1-4) override stall.
- call/ret without jb_enable are ignored.
- Trap or trap_return in the same cycle as jb_enable: the RAS is not modified.
- epc changes only on trap_enable.
- RAS updates (only when source 3 or 4 is selected):
  - call only: push pc + STEP. If full, overwrite the oldest entry (circular); count stays RAS_DEPTH.
  - ret only, not empty: pop; count-1.
  - ret only, empty: no change.
  - call && ret: top entry replaced with pc + STEP; count unchanged (empty: becomes a push, count=1).
- misaligned: flags the target of the selected source 1-4 when (target mod STEP) != 0. Informational only; the target is used unmodified.
- Reset mid-operation: immediate return to reset values; RAS contents are don't-care, count=0.

Decomposition:
- Package pc_pkg holds localparam source encodings (SRC_TRAP, SRC_TRET, SRC_RET, SRC_JB, SRC_HOLD, SRC_SEQ) and the RAS pointer-width function (clog2 of RAS_DEPTH).
- Sub-module ras_stack (parameters XLEN, RAS_DEPTH):
  - Circular buffer with top pointer and saturating count.
  - Inputs: push, pop, wdata. Outputs: top, empty, full.
- pc_unit holds the next-PC mux, the PC and EPC registers, and the misaligned check.

Test Plan:
- Reset with RESET_VECTOR=32'h100, STEP=4, release, 3 idle cycles -> pc 0x100,0x104,0x108,0x10C; epc=0x100.
- stall high 2 cycles at pc=0x108 -> pc holds 0x108; stall + jb_enable(0x200) -> pc=0x200 next cycle.
- pc=0x10, jb_enable+call to 0x80 -> pc=0x80, ras_top=0x14; later jb_enable+ret(jb_value=0xDEAD) -> pc=0x14, ras_empty=1.
- 5 calls with RAS_DEPTH=4 from pc 0x0,0x100,0x200,0x300,0x400 -> ras_full=1; 4 rets yield 0x404,0x304,0x204,0x104; 5th ret with empty RAS -> pc=jb_value.
- At pc=0x40, trap_enable(0x1000) with simultaneous jb_enable+call -> pc=0x1000, epc=0x40, RAS unchanged; trap_return -> pc=0x40.
- pc=32'hFFFF_FFFC idle -> pc=0; jb_value=0x102 -> misaligned=1 that cycle and pc=0x102; assert reset mid-stream -> pc=RESET_VECTOR immediately, ras_empty=1.
